// File: rtl/barrel_pkg.sv
// Shared types and defaults for the barrel spawn scheduler.
package barrel_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ_RAND  = 3'd1,
    S_WAIT_RAND = 3'd2,
    S_COUNT     = 3'd3,
    S_SPAWN     = 3'd4,
    S_WAIT_SLOT = 3'd5
  } spawn_state_t;

  localparam int MIN_DELAY_DEFAULT  = 4;
  localparam int MAX_ACTIVE_DEFAULT = 3;

endpackage

// File: rtl/frame_down_counter.sv
// Frame-paced down counter: loads a delay clamped up to MIN_DELAY,
// decrements on each frame pulse and flags expiry on the pulse that
// would take it from 1 to 0.
module frame_down_counter
  import barrel_pkg::*;
#(
  parameter int W         = 8,
  parameter int MIN_DELAY = MIN_DELAY_DEFAULT
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clear_i,
  input  logic         count_en_i,
  input  logic         sof_i,
  output logic         expire_o
);

  localparam logic [W-1:0] MIN_V = W'(MIN_DELAY);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Clamp happens before the load so a counting value is never zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = (load_val_i < MIN_V) ? MIN_V : load_val_i;
    else if (count_en_i && sof_i && cnt_q != '0)
      cnt_d = cnt_q - ONE_V;
  end

  // Delay register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = count_en_i && sof_i && (cnt_q == ONE_V);

endmodule

// File: rtl/barrel_spawn_timer.sv
// Barrel spawn scheduler: asks the random generator for a frame delay,
// waits that many frames, then hands a spawn request to the object pool
// while keeping the live-barrel count under MAX_ACTIVE.
module barrel_spawn_timer
  import barrel_pkg::*;
#(
  parameter int RAND_BITS  = 8,
  parameter int MIN_DELAY  = MIN_DELAY_DEFAULT,
  parameter int MAX_ACTIVE = MAX_ACTIVE_DEFAULT,
  parameter int ACT_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 enable,
  input  logic [RAND_BITS-1:0] rand_val,
  output logic                 rand_rise,
  output logic                 spawn_req,
  input  logic                 spawn_ack,
  input  logic                 barrel_done,
  output logic [ACT_BITS-1:0]  active_cnt,
  output logic                 busy
);

  localparam logic [ACT_BITS-1:0] MAX_V = ACT_BITS'(MAX_ACTIVE);
  localparam logic [ACT_BITS-1:0] ONE_V = ACT_BITS'(1);

  spawn_state_t        state_q, state_d;
  logic [ACT_BITS-1:0] act_q, act_d;
  logic                rise_q, rise_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                fire;
  logic                expire;

  // The handshake completes only while a request is actually outstanding.
  assign fire = (state_q == S_SPAWN) && spawn_ack;

  frame_down_counter #(
    .W         (RAND_BITS),
    .MIN_DELAY (MIN_DELAY)
  ) u_delay (
    .clk        (clk),
    .resetN     (resetN),
    .load_i     ((state_q == S_WAIT_RAND) && enable),
    .load_val_i (rand_val),
    .clear_i    (state_d == S_IDLE),
    .count_en_i (state_q == S_COUNT),
    .sof_i      (startOfFrame),
    .expire_o   (expire)
  );

  // Live count: spawn and destroy on the same clock cancel; both ends saturate.
  always_comb begin
    act_d = act_q;
    if (fire && barrel_done)
      act_d = act_q;
    else if (fire)
      act_d = (act_q >= MAX_V) ? MAX_V : act_q + ONE_V;
    else if (barrel_done && act_q != '0)
      act_d = act_q - ONE_V;
  end

  // State and live-count registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
    end
  end

  // Next state; enable drop aborts everywhere except an open spawn request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (enable) state_d = S_REQ_RAND;
      S_REQ_RAND:  state_d = enable ? S_WAIT_RAND : S_IDLE;
      S_WAIT_RAND: state_d = enable ? S_COUNT : S_IDLE;
      S_COUNT: begin
        if (!enable)     state_d = S_IDLE;
        else if (expire) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        if (fire) begin
          if (!enable)             state_d = S_IDLE;
          else if (act_d == MAX_V) state_d = S_WAIT_SLOT;
          else                     state_d = S_REQ_RAND;
        end
      end
      S_WAIT_SLOT: begin
        if (!enable)           state_d = S_IDLE;
        else if (act_q < MAX_V) state_d = S_REQ_RAND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered copies line up
  // with the state they describe; REQ_RAND never lasts two clocks, so
  // rand_rise can never be high twice in a row.
  always_comb begin
    rise_d = (state_d == S_REQ_RAND);
    req_d  = (state_d == S_SPAWN);
    busy_d = (state_d != S_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rise_q <= 1'b0;
      req_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      req_q  <= req_d;
      busy_q <= busy_d;
    end
  end

  assign rand_rise  = rise_q;
  assign spawn_req  = req_q;
  assign busy       = busy_q;
  assign active_cnt = act_q;

endmodule

// File: tb/tb_barrel_spawn_timer.sv
// Directed scenarios followed by a random soak, all checked cycle by cycle
// against a behavioural model of the spawn scheduler.
module tb_barrel_spawn_timer;

  localparam int RB   = 8;
  localparam int MIND = 4;
  localparam int MAXA = 3;
  localparam int AB   = 4;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          sof = 1'b0, enable = 1'b0, ack = 1'b0, done = 1'b0;
  logic [RB-1:0] rv = '0;
  logic          rand_rise, spawn_req, busy;
  logic [AB-1:0] active_cnt;

  int vectors = 0;
  int miscompares = 0;

  barrel_spawn_timer #(
    .RAND_BITS(RB), .MIN_DELAY(MIND), .MAX_ACTIVE(MAXA), .ACT_BITS(AB)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(enable),
    .rand_val(rv), .rand_rise(rand_rise), .spawn_req(spawn_req),
    .spawn_ack(ack), .barrel_done(done), .active_cnt(active_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the scheduler is doing, frames left, live barrels.
  localparam int OFF = 0, ASK = 1, GOTV = 2, TIMING = 3, REQ = 4, FULL = 5;
  int m_what = OFF;
  int m_left = 0;
  int m_live = 0;

  task automatic mdl_reset();
    m_what = OFF; m_left = 0; m_live = 0;
  endtask

  task automatic mdl_step();
    int live_new;
    bit spawned;
    spawned  = (m_what == REQ) && ack;
    live_new = m_live;
    if (spawned && !done)             live_new = (m_live < MAXA) ? m_live + 1 : MAXA;
    else if (!spawned && done && m_live > 0) live_new = m_live - 1;
    case (m_what)
      OFF:  if (enable) m_what = ASK;
      ASK:  m_what = enable ? GOTV : OFF;
      GOTV: begin
        if (enable) begin
          m_left = (int'(rv) < MIND) ? MIND : int'(rv);
          m_what = TIMING;
        end else m_what = OFF;
      end
      TIMING: begin
        if (!enable) m_what = OFF;
        else if (sof) begin
          m_left = m_left - 1;
          if (m_left == 0) m_what = REQ;
        end
      end
      REQ: if (spawned) m_what = !enable ? OFF : (live_new == MAXA ? FULL : ASK);
      FULL: begin
        if (!enable) m_what = OFF;
        else if (m_live < MAXA) m_what = ASK;
      end
      default: m_what = OFF;
    endcase
    m_live = live_new;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("rand_rise", {31'd0, rand_rise}, {31'd0, m_what == ASK});
    chk("spawn_req", {31'd0, spawn_req}, {31'd0, m_what == REQ});
    chk("busy", {31'd0, busy}, {31'd0, m_what != OFF});
    chk("active_cnt", {28'd0, active_cnt}, m_live);
  endtask

  // One clock: model advances on the same inputs the DUT samples.
  task automatic cyc();
    mdl_step();
    @(posedge clk); #1;
    chk_all();
    sof = 1'b0; ack = 1'b0; done = 1'b0;
  endtask

  // Frame pulse every third clock until spawn_req appears; returns pulse count.
  task automatic frames_to_spawn(output int pulses);
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      sof = (i % 3 == 2);
      if (sof) pulses++;
      cyc();
      if (spawn_req === 1'b1) return;
    end
    chk("spawn_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int p;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    resetN = 1'b1;

    // Scenario: delay of 10 frames
    rv = 8'd10; enable = 1'b1;
    cyc();
    chk("first_rise", {31'd0, rand_rise}, 32'd1);
    cyc();
    chk("rise_one_clock", {31'd0, rand_rise}, 32'd0);
    frames_to_spawn(p);
    chk("frames_rv10", p, 32'd10);
    ack = 1'b1; cyc();
    chk("cnt_after_ack", {28'd0, active_cnt}, 32'd1);
    chk("req_dropped", {31'd0, spawn_req}, 32'd0);

    // Scenario: small value is clamped to MIN_DELAY
    rv = 8'd2;
    frames_to_spawn(p);
    chk("frames_clamped", p, MIND);
    ack = 1'b1; cyc();

    // Scenario: fill to the cap, then free one slot
    rv = 8'd5;
    frames_to_spawn(p);
    chk("frames_rv5", p, 32'd5);
    ack = 1'b1; cyc();
    chk("cnt_full", {28'd0, active_cnt}, MAXA);
    for (int i = 0; i < 6; i++) begin
      sof = 1'b1; cyc();
      chk("full_no_rise", {31'd0, rand_rise}, 32'd0);
    end
    done = 1'b1; cyc();
    chk("cnt_after_done", {28'd0, active_cnt}, 32'd2);
    cyc();
    chk("rise_after_slot", {31'd0, rand_rise}, 32'd1);

    // Scenario: long stall on ack with enable dropped mid-wait
    frames_to_spawn(p);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) enable = 1'b0;
      cyc();
      chk("req_held", {31'd0, spawn_req}, 32'd1);
    end
    ack = 1'b1; cyc();
    chk("stall_cnt", {28'd0, active_cnt}, 32'd3);
    chk("stall_idle", {31'd0, busy}, 32'd0);

    // Scenario: simultaneous ack and done, and done at zero
    done = 1'b1; cyc();
    done = 1'b1; cyc();
    chk("cnt_one", {28'd0, active_cnt}, 32'd1);
    enable = 1'b1; cyc();
    frames_to_spawn(p);
    ack = 1'b1; done = 1'b1; cyc();
    chk("ack_done_same", {28'd0, active_cnt}, 32'd1);
    enable = 1'b0; cyc();
    done = 1'b1; cyc();
    done = 1'b1; cyc();
    chk("done_at_zero", {28'd0, active_cnt}, 32'd0);

    // Scenario: async reset while counting
    enable = 1'b1; rv = 8'd7; cyc(); cyc(); cyc(); cyc();
    done = 1'b0;
    resetN = 1'b0; #2;
    mdl_reset();
    chk_all();
    chk("rst_req", {31'd0, spawn_req}, 32'd0);
    @(posedge clk); #1;
    resetN = 1'b1;
    cyc();
    chk("rise_after_rst", {31'd0, rand_rise}, 32'd1);

    // Random soak
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 24) != 0);
      sof    = ($urandom_range(0, 3) == 0);
      ack    = ($urandom_range(0, 2) == 0);
      done   = ($urandom_range(0, 9) == 0);
      rv     = ($urandom_range(0, 7) == 0) ? RB'($urandom_range(0, 30))
                                           : RB'($urandom_range(0, 8));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
